regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Initiator-side controller that drives the 8x16 register file's write port (we, W, W_Addr) and both read ports (R_Addr, S_Addr).
- FILL operation: writes an arithmetic sequence into all eight registers, one per cycle.
- SCAN operation: steps the two read addresses through adjacent register pairs on push-button pulses and registers the returned R/S data for the display controller.
- Sits between the board inputs (one-shot buttons, switches) and the register file at the lab top level.

Parameters:
- DW, 16, data width of W/R/S.
- AW, 3, address width; register count is 2**AW.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  one-cycle pulse; begins an operation, honoured only in IDLE.
- mode  in  1  sampled with start: 0 = FILL, 1 = SCAN.
- seed  in  DW  first value written in FILL; latched on start.
- inc  in  DW  increment between successive FILL values; latched on start.
- step  in  1  one-cycle pulse; advances the read pointer in SCAN.
- abort  in  1  returns to IDLE from any state.
- R_in  in  DW  R data returned by the register file (combinational read of R_Addr).
- S_in  in  DW  S data returned by the register file (combinational read of S_Addr).
- we  out  1  register-file write enable (registered).
- W  out  DW  write data (registered).
- W_Addr  out  AW  write address (registered).
- R_Addr  out  AW  R read address = rptr.
- S_Addr  out  AW  S read address = rptr+1 mod 2**AW.
- disp_R  out  DW  registered copy of R_in.
- disp_S  out  DW  registered copy of S_in.
- busy  out  1  high in FILL or SCAN.
- done  out  1  one-cycle pulse at FILL completion.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE, we=0, W=0, W_Addr=0, rptr=0 (R_Addr=0, S_Addr=1), disp_R=0, disp_S=0, busy=0, done=0. Reset overrides every other input, including mid-FILL: we drops the next edge.
- States: IDLE, FILL, SCAN. All outputs registered; no combinational input-to-output path.
- IDLE: we=0.
  - start & mode=0 -> FILL; latch acc=seed, inc_q=inc, cnt=0.
  - start & mode=1 -> SCAN; rptr=0.
- FILL:
  - Each cycle: we=1, W_Addr=cnt, W=acc; then acc=acc+inc_q (mod 2**DW, carry discarded) and cnt=cnt+1.
  - Exactly 2**AW write cycles, addresses 0..7 in order.
  - After the cycle with W_Addr=7: next cycle we=0, done=1 for one cycle, state=IDLE.
  - start and step are ignored.
- SCAN:
  - we=0.
  - step: rptr=rptr+1, wrapping 7->0; R_Addr/S_Addr update the edge after step.
  - disp_R<=R_in and disp_S<=S_in every cycle in SCAN. Latency from step to updated disp_R/disp_S is 2 cycles.
  - disp_R/disp_S hold their values outside SCAN.
  - start is ignored. SCAN persists until abort.
- abort: next edge state=IDLE, we=0. No done pulse. Registers already written keep their contents; rptr and disp_* hold.
- Priority: reset > abort > step/start.
- start is ignored when busy=1. Simultaneous abort+step: abort wins and rptr is unchanged.
- busy=1 exactly in FILL/SCAN, including the first FILL write cycle. done and busy never overlap.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, FILL=2'b01, SCAN=2'b10.
  - DW/AW defaults.
  - Mode constants MODE_FILL=0, MODE_SCAN=1.
- Single module, no sub-module. Counter and pointer are inline.
- The register file is instantiated beside this block at top level, not inside it.

Test Plan:
- FILL, seed=16'h1000, inc=16'h0011 -> 8 consecutive we=1 cycles, W_Addr 0..7, W 16'h1000..16'h1077; done pulse on the 9th cycle; readback reg7=16'h1077.
- FILL wrap, seed=16'hFFF0, inc=16'h0004 -> reg3=16'hFFFC, reg4=16'h0000, reg7=16'h000C.
- SCAN after the first FILL, 8 step pulses -> (R_Addr,S_Addr) = (0,1),(1,2)...(7,0) then (0,1); at rptr=7, disp_R=16'h1077 and disp_S=16'h1000, both 2 cycles after the step.
- abort asserted on the 4th FILL write cycle (W_Addr=3) -> we=0 next edge, no done pulse; regs 0..3 hold 16'h1000..16'h1033, regs 4..7 unchanged.
- start pulses during FILL and during SCAN -> no state change, no restart.
- reset low mid-SCAN at rptr=5 -> all outputs take reset values next edge; abort+step in the same cycle leaves rptr unchanged.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// rtl/regfile_sequencer_pkg.sv - shared types and constants for the register-file sequencer
package regfile_sequencer_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        SCAN = 2'b10
    } state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - drives register-file write/read ports for FILL and SCAN operations
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [DW-1:0] seed,
    input  logic [DW-1:0] inc,
    input  logic          step,
    input  logic          abort,
    input  logic [DW-1:0] R_in,
    input  logic [DW-1:0] S_in,
    output logic          we,
    output logic [DW-1:0] W,
    output logic [AW-1:0] W_Addr,
    output logic [AW-1:0] R_Addr,
    output logic [AW-1:0] S_Addr,
    output logic [DW-1:0] disp_R,
    output logic [DW-1:0] disp_S,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state;
    logic [DW-1:0] inc_q;

    // W doubles as the sequence accumulator and W_Addr as the write counter:
    // the value on the bus is always the one being written this cycle.
    // R_Addr is the read pointer; S_Addr is kept one ahead as its own register.
    // Sequencer state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            we     <= 1'b0;
            W      <= '0;
            W_Addr <= '0;
            R_Addr <= '0;
            S_Addr <= AW'(1);
            disp_R <= '0;
            disp_S <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            inc_q  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                we    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        we <= 1'b0;
                        if (start) begin
                            case (mode)
                                MODE_FILL: begin
                                    // first write goes out on the cycle busy rises
                                    state  <= FILL;
                                    busy   <= 1'b1;
                                    we     <= 1'b1;
                                    W      <= seed;
                                    W_Addr <= '0;
                                    inc_q  <= inc;
                                end
                                MODE_SCAN: begin
                                    state  <= SCAN;
                                    busy   <= 1'b1;
                                    R_Addr <= '0;
                                    S_Addr <= AW'(1);
                                end
                            endcase
                        end
                    end
                    FILL: begin
                        if (W_Addr == LAST_ADDR) begin
                            state <= IDLE;
                            we    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            W      <= W + inc_q;
                            W_Addr <= W_Addr + AW'(1);
                        end
                    end
                    SCAN: begin
                        we     <= 1'b0;
                        disp_R <= R_in;
                        disp_S <= S_in;
                        if (step) begin
                            R_Addr <= R_Addr + AW'(1);
                            S_Addr <= S_Addr + AW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        we    <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - directed self-checking bench for regfile_sequencer
module tb_regfile_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] seed;
    logic [15:0] inc;
    logic        step;
    logic        abort;
    logic [15:0] R_in;
    logic [15:0] S_in;
    logic        we;
    logic [15:0] W;
    logic [2:0]  W_Addr;
    logic [2:0]  R_Addr;
    logic [2:0]  S_Addr;
    logic [15:0] disp_R;
    logic [15:0] disp_S;
    logic        busy;
    logic        done;

    logic [15:0] rf [8];

    int tests;
    int failed;

    regfile_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .seed   (seed),
        .inc    (inc),
        .step   (step),
        .abort  (abort),
        .R_in   (R_in),
        .S_in   (S_in),
        .we     (we),
        .W      (W),
        .W_Addr (W_Addr),
        .R_Addr (R_Addr),
        .S_Addr (S_Addr),
        .disp_R (disp_R),
        .disp_S (disp_S),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file beside the sequencer: sync write, combinational reads
    always @(posedge clk) begin
        if (we) rf[W_Addr] <= W;
    end
    assign R_in = rf[R_Addr];
    assign S_in = rf[S_Addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] fv(input int k);
        fv = 16'h1000 + 16'(k * 16'h0011);
    endfunction

    task automatic check_reset(input string where);
        check({where, "_we"},     we,     32'd0);
        check({where, "_W"},      W,      32'd0);
        check({where, "_W_Addr"}, W_Addr, 32'd0);
        check({where, "_R_Addr"}, R_Addr, 32'd0);
        check({where, "_S_Addr"}, S_Addr, 32'd1);
        check({where, "_disp_R"}, disp_R, 32'd0);
        check({where, "_disp_S"}, disp_S, 32'd0);
        check({where, "_busy"},   busy,   32'd0);
        check({where, "_done"},   done,   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw_done;
        logic [15:0] wrap_vals [8];
        tests = 0;
        failed = 0;
        for (int i = 0; i < 8; i++) rf[i] = 16'hA000 + 16'(i);
        wrap_vals = '{16'hFFF0, 16'hFFF4, 16'hFFF8, 16'hFFFC,
                      16'h0000, 16'h0004, 16'h0008, 16'h000C};
        reset = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; inc = '0;
        step = 1'b0; abort = 1'b0;
        repeat (2) tick();
        check_reset("por");
        reset = 1'b1;
        tick();

        // FILL seed 1000 inc 0011, with a stray start pulse mid-fill
        seed = 16'h1000; inc = 16'h0011; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("fill_we",   we,     32'd1);
            check("fill_addr", W_Addr, 32'(i));
            check("fill_W",    W,      32'(fv(i)));
            check("fill_busy", busy,   32'd1);
            check("fill_done", done,   32'd0);
            if (i == 2) begin start = 1'b1; mode = 1'b1; end
            tick();
            start = 1'b0; mode = 1'b0;
        end
        check("fill_end_we",   we,   32'd0);
        check("fill_end_done", done, 32'd1);
        check("fill_end_busy", busy, 32'd0);
        tick();
        check("done_one_cycle", done, 32'd0);
        check("rf0_fill", rf[0], 32'h1000);
        check("rf7_fill", rf[7], 32'h1077);

        // SCAN over the filled registers, 8 steps, stray start mid-scan
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("scan_busy", busy, 32'd1);
        for (int k = 0; k < 8; k++) begin
            check("scan_R_Addr", R_Addr, 32'(k));
            check("scan_S_Addr", S_Addr, 32'((k + 1) % 8));
            tick();
            check("scan_disp_R", disp_R, 32'(fv(k)));
            check("scan_disp_S", disp_S, 32'(fv((k + 1) % 8)));
            step = 1'b1;
            if (k == 3) begin start = 1'b1; mode = 1'b0; end
            tick();
            step = 1'b0; start = 1'b0;
            if (k == 3) check("scan_start_ignored_we", we, 32'd0);
        end
        check("scan_wrap_R", R_Addr, 32'd0);
        check("scan_wrap_S", S_Addr, 32'd1);
        check("scan_still_busy", busy, 32'd1);

        // abort + step together at rptr 5: abort wins, pointer holds
        repeat (5) begin step = 1'b1; tick(); step = 1'b0; end
        tick();
        check("pre_abort_disp_R", disp_R, 32'(fv(5)));
        abort = 1'b1; step = 1'b1;
        tick();
        abort = 1'b0; step = 1'b0;
        check("abort_busy",   busy,   32'd0);
        check("abort_R_Addr", R_Addr, 32'd5);
        check("abort_S_Addr", S_Addr, 32'd6);
        check("abort_disp_R", disp_R, 32'(fv(5)));
        check("abort_done",   done,   32'd0);

        // reset mid-SCAN at rptr 5
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) begin step = 1'b1; tick(); step = 1'b0; end
        tick();
        check("scan2_R_Addr", R_Addr, 32'd5);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset("scan_rst");

        // FILL with carry wrap
        seed = 16'hFFF0; inc = 16'h0004; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("wrap_done_seen", done, 32'd1);
        check("rf3_wrap", rf[3], 32'hFFFC);
        check("rf4_wrap", rf[4], 32'h0000);
        check("rf7_wrap", rf[7], 32'h000C);

        // abort on the 4th FILL write cycle
        seed = 16'h1000; inc = 16'h0011; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_fill_addr", W_Addr, 32'd3);
        check("abort_fill_we",   we,     32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_fill_we_drop", we,   32'd0);
        check("abort_fill_busy",    busy, 32'd0);
        saw_done = 1'b0;
        repeat (12) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("abort_fill_no_done", saw_done, 32'd0);
        for (int i = 0; i < 4; i++) check("abort_rf_low", rf[i], 32'(fv(i)));
        for (int i = 4; i < 8; i++) check("abort_rf_high", rf[i], 32'(wrap_vals[i]));

        // reset mid-FILL drops we on the next edge
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rstfill_we_before", we, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset("fill_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
